// File: rtl/latch_bank_writer.sv
// Write sequencer for a bank of transparent D-latches: setup, one-hot gate pulse, hold, or timed clear.
// Optional macro LATCH_READBACK_EN adds LAT_Q readback checking at the end of each sequence.
module latch_bank_writer #(
  parameter int DW        = 8,
  parameter int NW        = 4,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int CLR_CYC   = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_REQ,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [DW-1:0] WR_DATA,
  input  logic          CLR_REQ,
`ifdef LATCH_READBACK_EN
  input  logic [NW*DW-1:0] LAT_Q,
`endif
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [DW-1:0] LAT_D,
  output logic [NW-1:0] LAT_G,
  output logic          LAT_CLR
);

  localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_GATE,
    S_HOLD,
    S_CLEAR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_lat_d, w_lat_d_nxt;
  logic [NW-1:0] r_lat_g, w_lat_g_nxt;
  logic          r_lat_clr, w_lat_clr_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic [NW-1:0] w_onehot;
  logic          w_in_range;
  logic          w_wr_bad;
  logic          w_clr_bad;

  assign w_onehot   = NW'(1) << r_addr;
  assign w_in_range = ({1'b0, WR_ADDR} < (AW+1)'(NW));

`ifdef LATCH_READBACK_EN
  logic [DW-1:0] w_q_word;
  always_comb begin
    w_q_word = '0;
    for (int i = 0; i < NW; i++) begin
      if (r_addr == AW'(i)) w_q_word = LAT_Q[i*DW +: DW];
    end
  end
  assign w_wr_bad  = (w_q_word != r_lat_d);
  assign w_clr_bad = (LAT_Q != '0);
`else
  assign w_wr_bad  = 1'b0;
  assign w_clr_bad = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_lat_d_nxt   = r_lat_d;
    w_lat_g_nxt   = '0;
    w_lat_clr_nxt = 1'b1;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (CLR_REQ) begin
          w_state_nxt   = S_CLEAR;
          w_cnt_nxt     = CW'(CLR_CYC - 1);
          w_lat_clr_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
        end else if (WR_REQ) begin
          if (w_in_range) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = CW'(SETUP_CYC - 1);
            w_addr_nxt  = WR_ADDR;
            w_lat_d_nxt = WR_DATA;
            w_busy_nxt  = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GATE;
          w_cnt_nxt   = CW'(PULSE_CYC - 1);
          w_lat_g_nxt = w_onehot;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_GATE: begin
        // Gate stays high only while more pulse cycles remain.
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CW'(HOLD_CYC - 1);
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
          w_lat_g_nxt = w_onehot;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = w_wr_bad;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_CLEAR: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = w_clr_bad;
        end else begin
          w_cnt_nxt     = r_cnt - CW'(1);
          w_lat_clr_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset holds LAT_CLR low so the bank is cleared for as long as reset is asserted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_lat_d   <= '0;
      r_lat_g   <= '0;
      r_lat_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_lat_d   <= w_lat_d_nxt;
      r_lat_g   <= w_lat_g_nxt;
      r_lat_clr <= w_lat_clr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;
  assign LAT_D   = r_lat_d;
  assign LAT_G   = r_lat_g;
  assign LAT_CLR = r_lat_clr;

endmodule
